ifetch_imem: RTL and testbench

IFETCH_IMEM -- requirements
Module: ifetch_imem

---
 rtl/ifetch_pkg.sv | 9 +
 rtl/ifetch_imem_if.sv | 31 +++
 rtl/ifetch_rsp_fifo.sv | 55 +++++
 rtl/ifetch_imem.sv | 61 ++++++
 tb/tb_ifetch_imem.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/ifetch_pkg.sv
// Shared constants for the instruction-fetch path: machine word width,
// instruction SRAM word-address width and response buffer depth.
package ifetch_pkg;

  localparam int XLEN             = 32;
  localparam int IMEM_AW          = 15;
  localparam int IFETCH_RSP_DEPTH = 3;

endpackage : ifetch_pkg

// File: rtl/ifetch_imem_if.sv
// Bus bundles for the fetch unit: the request/response fetch channel and the
// single-port instruction SRAM connection.
interface ifetch_if_t #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req_vld;
  logic          req_rdy;
  logic [AW-1:0] req_pc;
  logic          rsp_vld;
  logic          rsp_rdy;
  logic [DW-1:0] rsp_ir;

  modport master (output req_vld, req_pc, rsp_rdy,
                  input  req_rdy, rsp_vld, rsp_ir);
  modport slave  (input  req_vld, req_pc, rsp_rdy,
                  output req_rdy, rsp_vld, rsp_ir);
endinterface : ifetch_if_t

interface sram_if_t #(
  parameter int AW = 15,
  parameter int DW = 32
);
  logic [AW-1:0] addr;
  logic          wen;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;

  modport master (output addr, wen, wdata, input  rdata);
  modport slave  (input  addr, wen, wdata, output rdata);
endinterface : sram_if_t

// File: rtl/ifetch_rsp_fifo.sv
// Small in-order response buffer: circular storage with a head-of-queue
// read port; pointers and occupancy reset, the data array does not.
module ifetch_rsp_fifo
  import ifetch_pkg::*;
#(
  parameter  int DEPTH = IFETCH_RSP_DEPTH,
  parameter  int DW    = XLEN,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [CW-1:0] count,
  output logic [DW-1:0] head
);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Guards keep the buffer consistent even if a caller misbehaves.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule : ifetch_rsp_fifo

// File: rtl/ifetch_imem.sv
// Instruction fetch responder: turns fetch requests into synchronous SRAM
// reads and returns the words in order through a small response buffer.
module ifetch_imem
  import ifetch_pkg::*;
#(
  parameter int AW      = XLEN,
  parameter int DW      = XLEN,
  parameter int SRAM_AW = IMEM_AW
) (
  input  logic     clk,
  input  logic     rst,
  ifetch_if_t.slave ifetch,
  sram_if_t.master  sram
);

  localparam int DEPTH = IFETCH_RSP_DEPTH;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          s1_vld;
  logic          accept;
  logic          pop;
  logic [CW-1:0] count;
  logic [DW-1:0] head;
  logic [CW:0]   committed;
  logic          unused_pc_bits;

  // Word-aligned index; byte offset and high PC bits simply alias.
  assign sram.addr      = ifetch.req_pc[SRAM_AW+1:2];
  assign sram.wen       = 1'b0;
  assign sram.wdata     = '0;
  assign unused_pc_bits = ^{ifetch.req_pc[1:0], ifetch.req_pc[AW-1:SRAM_AW+2]};

  // Reserve a slot for every read already launched so the buffer never
  // overflows; depends on registered state only.
  assign committed      = {1'b0, count} + {{CW{1'b0}}, s1_vld};
  assign ifetch.req_rdy = !rst && (committed < (CW+1)'(DEPTH));
  assign accept         = ifetch.req_vld && ifetch.req_rdy;

  assign ifetch.rsp_vld = (count != '0);
  assign ifetch.rsp_ir  = ifetch.rsp_vld ? head : '0;
  assign pop            = ifetch.rsp_vld && ifetch.rsp_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) s1_vld <= 1'b0;
    else     s1_vld <= accept;
  end

  ifetch_rsp_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (s1_vld),
    .push_data (sram.rdata),
    .pop       (pop),
    .count     (count),
    .head      (head)
  );

endmodule : ifetch_imem

// File: tb/tb_ifetch_imem.sv
// Self-checking bench for ifetch_imem: directed vector table plus scoreboarded
// streaming, back-pressure, mid-stream reset and random-ready sequences.
module tb_ifetch_imem;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int SRAM_AW = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ifetch_if_t #(.AW(AW), .DW(DW)) ifetch ();
  sram_if_t   #(.AW(SRAM_AW), .DW(DW)) sram ();

  ifetch_imem #(.AW(AW), .DW(DW), .SRAM_AW(SRAM_AW)) dut (
    .clk    (clk),
    .rst    (rst),
    .ifetch (ifetch),
    .sram   (sram)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [1 << SRAM_AW];

  function automatic logic [DW-1:0] exp_word(input logic [SRAM_AW-1:0] a);
    return (a == 15'd4) ? 32'h0000_0013 : (32'hAB00_0000 | {17'h0, a});
  endfunction

  // Synchronous-read SRAM model, one cycle of latency.
  always @(posedge clk) sram.rdata <= mem[sram.addr];

  int tests    = 0;
  int failures = 0;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        req_vld;
    logic [31:0] req_pc;
    logic        rsp_rdy;
    logic        exp_req_rdy;
    logic [14:0] exp_addr;
    logic        exp_rsp_vld;
    logic [31:0] exp_rsp_ir;
  } vec_t;

  vec_t vecs [8];

  task automatic applyStimulus(input vec_t v);
    ifetch.req_vld = v.req_vld;
    ifetch.req_pc  = v.req_pc;
    ifetch.rsp_rdy = v.rsp_rdy;
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    checkVal($sformatf("vec%0d.req_rdy", idx), {31'h0, ifetch.req_rdy}, {31'h0, v.exp_req_rdy});
    checkVal($sformatf("vec%0d.addr", idx), {17'h0, sram.addr}, {17'h0, v.exp_addr});
    checkVal($sformatf("vec%0d.rsp_vld", idx), {31'h0, ifetch.rsp_vld}, {31'h0, v.exp_rsp_vld});
    checkVal($sformatf("vec%0d.rsp_ir", idx), ifetch.rsp_ir, v.exp_rsp_ir);
    checkVal($sformatf("vec%0d.wen", idx), {31'h0, sram.wen}, 32'h0);
  endtask

  // Scoreboard state shared by the sequence phases.
  logic [31:0] exp_q [$];
  int          received    = 0;
  int          accepted    = 0;
  int          side_errors = 0;
  logic        prev_hold   = 1'b0;
  logic [31:0] prev_ir     = '0;
  logic        last_acc, last_req_rdy, last_rsp_vld;

  task automatic runCycle(input logic vld, input logic [31:0] pc, input logic rdy);
    logic [31:0] e;
    ifetch.req_vld = vld;
    ifetch.req_pc  = pc;
    ifetch.rsp_rdy = rdy;
    @(negedge clk);
    last_req_rdy = ifetch.req_rdy;
    last_rsp_vld = ifetch.rsp_vld;
    last_acc     = vld && ifetch.req_rdy;
    if (sram.wen !== 1'b0 || sram.wdata !== '0) side_errors++;
    if (!ifetch.rsp_vld && ifetch.rsp_ir !== '0) side_errors++;
    if (prev_hold) begin
      checkVal("hold.rsp_vld", {31'h0, ifetch.rsp_vld}, 32'h1);
      checkVal("hold.rsp_ir", ifetch.rsp_ir, prev_ir);
    end
    if (ifetch.rsp_vld && rdy) begin
      if (exp_q.size() == 0) begin
        checkVal("sb.unexpected_rsp", ifetch.rsp_ir, 32'hxxxx_xxxx);
      end else begin
        e = exp_q.pop_front();
        checkVal($sformatf("sb.rsp%0d", received), ifetch.rsp_ir, e);
      end
      received++;
    end
    if (last_acc) begin
      exp_q.push_back(exp_word(pc[SRAM_AW+1:2]));
      accepted++;
    end
    prev_hold = ifetch.rsp_vld && !rdy;
    prev_ir   = ifetch.rsp_ir;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          acc_cnt;
    int          rsp_cnt;
    int          cyc;
    logic [31:0] next_pc;

    for (int i = 0; i < (1 << SRAM_AW); i++) mem[i] = exp_word(SRAM_AW'(i));

    vecs[0] = '{1'b1, 32'h0000_0010, 1'b0, 1'b1, 15'h0004, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 32'h0000_0010, 1'b0, 1'b1, 15'h0004, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 32'h0000_0010, 1'b0, 1'b1, 15'h0004, 1'b1, 32'h0000_0013};
    vecs[3] = '{1'b0, 32'h0000_0010, 1'b1, 1'b1, 15'h0004, 1'b1, 32'h0000_0013};
    vecs[4] = '{1'b1, 32'h0002_0006, 1'b1, 1'b1, 15'h0001, 1'b0, 32'h0};
    vecs[5] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 15'h0000, 1'b0, 32'h0};
    vecs[6] = '{1'b0, 32'hFFFF_FFFC, 1'b1, 1'b1, 15'h7FFF, 1'b1, 32'hAB00_0001};
    vecs[7] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 15'h0000, 1'b0, 32'h0};

    ifetch.req_vld = 1'b0;
    ifetch.req_pc  = '0;
    ifetch.rsp_rdy = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkVal("reset.req_rdy", {31'h0, ifetch.req_rdy}, 32'h0);
    checkVal("reset.rsp_vld", {31'h0, ifetch.rsp_vld}, 32'h0);
    checkVal("reset.rsp_ir", ifetch.rsp_ir, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Directed table: single fetch, hold, then aliased/misaligned PC.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput(i, vecs[i]);
      @(posedge clk);
      #1;
    end

    // Streaming with the consumer always ready.
    rsp_cnt = 0;
    for (int i = 0; i < 18; i++) begin
      runCycle(i < 16, 32'(i * 4), 1'b1);
      if (i < 16) checkVal($sformatf("stream.req_rdy%0d", i), {31'h0, last_req_rdy}, 32'h1);
      if (i >= 2 && last_rsp_vld) rsp_cnt++;
    end
    checkVal("stream.rsp_per_cycle", rsp_cnt, 16);
    checkVal("stream.pending", exp_q.size(), 0);

    // Back-pressure: consumer stalled, requester pushes continuously.
    acc_cnt = 0;
    next_pc = 32'h0000_0100;
    for (int i = 0; i < 6; i++) begin
      runCycle(1'b1, next_pc, 1'b0);
      if (last_acc) begin
        acc_cnt++;
        next_pc += 4;
      end
      if (i >= 3) checkVal($sformatf("bp.req_rdy%0d", i), {31'h0, last_req_rdy}, 32'h0);
    end
    checkVal("bp.accepts", acc_cnt, 3);
    rsp_cnt = received;
    for (int i = 0; i < 5; i++) runCycle(1'b0, 32'h0, 1'b1);
    checkVal("bp.drained", received - rsp_cnt, 3);
    checkVal("bp.pending", exp_q.size(), 0);

    // Reset with two buffered responses and one read in flight.
    for (int i = 0; i < 3; i++) runCycle(1'b1, 32'(32'h200 + i * 4), 1'b0);
    ifetch.req_vld = 1'b0;
    rst = 1'b1;
    #1;
    checkVal("midrst.rsp_vld", {31'h0, ifetch.rsp_vld}, 32'h0);
    checkVal("midrst.req_rdy", {31'h0, ifetch.req_rdy}, 32'h0);
    checkVal("midrst.rsp_ir", ifetch.rsp_ir, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    prev_hold = 1'b0;
    runCycle(1'b0, 32'h0, 1'b1);
    checkVal("postrst.req_rdy", {31'h0, last_req_rdy}, 32'h1);
    checkVal("postrst.rsp_vld", {31'h0, last_rsp_vld}, 32'h0);
    rsp_cnt = received;
    for (int i = 0; i < 3; i++) runCycle(1'b0, 32'h0, 1'b1);
    checkVal("postrst.stale", received - rsp_cnt, 0);
    runCycle(1'b1, 32'h0000_0010, 1'b1);
    for (int i = 0; i < 3; i++) runCycle(1'b0, 32'h0, 1'b1);
    checkVal("postrst.fetch", received - rsp_cnt, 1);

    // Random consumer readiness over 1000 fetches.
    accepted = 0;
    received = 0;
    cyc      = 0;
    while (received < 1000 && cyc < 20000) begin
      runCycle((accepted < 1000) && ($urandom_range(0, 3) != 0), $urandom(),
               1'($urandom_range(0, 1)));
      cyc++;
    end
    checkVal("rand.received", received, 1000);
    checkVal("rand.pending", exp_q.size(), 0);
    checkVal("side.wen_wdata_ir", side_errors, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule : tb_ifetch_imem
